// File: rtl/serial_frame_rcvr.sv
// serial_frame_rcvr: oversampled serial frame receiver (quiet-arm, start, header, payload, odd parity, stop) with short frames.
// Latency: result pulse one cycle after the decision sample of the last examined bit slot (one more with MAJ_VOTE_EN).
// Backpressure: none; the line free-runs and results are one-cycle pulses the decoder must take. Option macro: MAJ_VOTE_EN.
module serial_frame_rcvr #(
    parameter int              OSR      = 4,
    parameter int              FRAME_W  = 20,
    parameter int              HDR_W    = 4,
    parameter logic [HDR_W-1:0] SHORT_A = 4'b1100,
    parameter logic [HDR_W-1:0] SHORT_B = 4'b1000,
    parameter int              IDLE_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rcvd,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_short,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int SC_W = $clog2(OSR);
    localparam int BC_W = $clog2(FRAME_W + 3);
    localparam int IC_W = $clog2(IDLE_CYC + 1);

`ifdef MAJ_VOTE_EN
    localparam int DEC_IDX = OSR / 2 + 1;
`else
    localparam int DEC_IDX = OSR / 2;
`endif

    localparam logic [SC_W-1:0] DEC_S     = SC_W'(DEC_IDX);
    localparam logic [SC_W-1:0] LAST_S    = SC_W'(OSR - 1);
    localparam logic [BC_W-1:0] HDR_LAST  = BC_W'(HDR_W);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(FRAME_W);
    localparam logic [IC_W-1:0] IDLE_ARM  = IC_W'(IDLE_CYC - 1);
    localparam logic [IC_W-1:0] IDLE_SAT  = IC_W'(IDLE_CYC);

    localparam logic [2:0] ST_QUIET = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_HDR   = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_PAR   = 3'd5;
    localparam logic [2:0] ST_STOP  = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [IC_W-1:0]    idle_q, idle_d;
    logic [SC_W-1:0]    samp_q, samp_d;
    logic [BC_W-1:0]    bit_q, bit_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [FRAME_W-1:0] frame_data_q, frame_data_d;
    logic               frame_short_q, frame_short_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;
    logic [HDR_W-1:0]   hdr_now;
    logic               line_v;
    logic               stored_b;

`ifdef MAJ_VOTE_EN
    // Two earlier mid-bit samples; the third is the live line at the decision index.
    logic s1_q, s1_d, s2_q, s2_d;
    assign line_v = (s1_q & s2_q) | (s1_q & rcvd) | (s2_q & rcvd);
`else
    assign line_v = rcvd;
`endif

    // The line is inverted: a low line carries a stored 1.
    assign stored_b = ~line_v;

    // Next-state: quiet-period arming, per-slot sample/bit counting and the frame decisions.
    always_comb begin
        state_d       = state_q;
        idle_d        = idle_q;
        samp_d        = samp_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        frame_data_d  = frame_data_q;
        frame_short_d = frame_short_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        hdr_now       = '0;
`ifdef MAJ_VOTE_EN
        s1_d          = s1_q;
        s2_d          = s2_q;
`endif
        case (state_q)
            ST_QUIET: begin
                if (rcvd) begin
                    idle_d = '0;
                end else if (idle_q >= IDLE_ARM) begin
                    idle_d  = IDLE_SAT;
                    state_d = ST_ARMED;
                end else begin
                    idle_d = idle_q + IC_W'(1);
                end
            end
            ST_ARMED: begin
                // This cycle is sample 0 of the start bit.
                if (rcvd) begin
                    state_d = ST_START;
                    samp_d  = SC_W'(1);
                    bit_d   = '0;
                    par_d   = 1'b1;
                end
            end
            ST_START, ST_HDR, ST_DATA, ST_PAR, ST_STOP: begin
`ifdef MAJ_VOTE_EN
                if (samp_q == SC_W'(OSR / 2 - 1)) s1_d = rcvd;
                if (samp_q == SC_W'(OSR / 2))     s2_d = rcvd;
`endif
                if (samp_q == LAST_S) begin
                    samp_d = '0;
                    bit_d  = bit_q + BC_W'(1);
                    case (state_q)
                        ST_START: state_d = ST_HDR;
                        ST_HDR:   if (bit_q == HDR_LAST)  state_d = ST_DATA;
                        ST_DATA:  if (bit_q == DATA_LAST) state_d = ST_PAR;
                        ST_PAR:   state_d = ST_STOP;
                        default:  ;
                    endcase
                end else begin
                    samp_d = samp_q + SC_W'(1);
                end
                if (samp_q == DEC_S) begin
                    case (state_q)
                        ST_START: begin
                            if (!line_v) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b01;
                                state_d     = ST_QUIET;
                            end
                        end
                        ST_HDR, ST_DATA: begin
                            shreg_d = {shreg_q[FRAME_W-2:0], stored_b};
                            par_d   = par_q ^ stored_b;
                            hdr_now = shreg_d[HDR_W-1:0];
                            if (state_q == ST_HDR && bit_q == HDR_LAST &&
                                (hdr_now == SHORT_A || hdr_now == SHORT_B)) begin
                                frame_valid_d = 1'b1;
                                frame_short_d = 1'b1;
                                frame_data_d  = {{(FRAME_W-HDR_W){1'b0}}, hdr_now};
                                state_d       = ST_QUIET;
                            end
                        end
                        ST_PAR: par_d = par_q ^ stored_b;
                        ST_STOP: begin
                            // Stop error outranks parity error.
                            if (line_v) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b11;
                            end else if (par_q) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b10;
                            end else begin
                                frame_valid_d = 1'b1;
                                frame_short_d = 1'b0;
                                frame_data_d  = shreg_q;
                            end
                            state_d = ST_QUIET;
                        end
                        default: ;
                    endcase
                end
                // Every frame exit demands a fresh quiet period.
                if (state_d == ST_QUIET) begin
                    idle_d = '0;
                    samp_d = '0;
                    bit_d  = '0;
                end
            end
            default: state_d = ST_QUIET;
        endcase
        busy_d = (state_d != ST_QUIET) && (state_d != ST_ARMED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_QUIET;
            idle_q        <= '0;
            samp_q        <= '0;
            bit_q         <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            frame_data_q  <= '0;
            frame_short_q <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            busy_q        <= 1'b0;
`ifdef MAJ_VOTE_EN
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idle_q        <= idle_d;
            samp_q        <= samp_d;
            bit_q         <= bit_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            frame_data_q  <= frame_data_d;
            frame_short_q <= frame_short_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            busy_q        <= busy_d;
`ifdef MAJ_VOTE_EN
            s1_q          <= s1_d;
            s2_q          <= s2_d;
`endif
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_short = frame_short_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_frame_rcvr.sv
// tb_serial_frame_rcvr: directed and randomized frames against a frame-level reference model.
// Latency: expected pulse time derived from slot index * OSR + decision index.
// Backpressure: none; the bench drives the line freely and logs every output pulse.
`timescale 1ns/1ps
module tb_serial_frame_rcvr;

    localparam int OSR      = 4;
    localparam int FRAME_W  = 20;
    localparam int HDR_W    = 4;
    localparam int IDLE_CYC = 64;
`ifdef MAJ_VOTE_EN
    localparam int DEC = OSR / 2 + 1;
    localparam bit MAJ = 1'b1;
`else
    localparam int DEC = OSR / 2;
    localparam bit MAJ = 1'b0;
`endif
    // Short frames end at slot HDR_W, long frames at the stop slot FRAME_W+2.
    localparam int SHORT_OFF = HDR_W * OSR + DEC;
    localparam int LONG_OFF  = (FRAME_W + 2) * OSR + DEC;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rcvd  = 1'b0;
    logic [19:0] frame_data;
    logic        frame_short, frame_valid, frame_err, busy;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    serial_frame_rcvr dut (
        .clk(clk), .rst_n(rst_n), .rcvd(rcvd),
        .frame_data(frame_data), .frame_short(frame_short),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    typedef struct packed {
        int          stamp;
        logic        valid;
        logic        err;
        logic [1:0]  code;
        logic [19:0] data;
        logic        shrt;
    } ev_t;

    ev_t ev_q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  busy_rise = -1, busy_fall = -1, both_cnt = 0;
    bit  busy_prev = 1'b0;
    int  checks = 0, errors = 0;

    // Model history: held outputs as they should be after the last pulse.
    logic [19:0] last_good  = '0;
    logic        last_short = 1'b0;
    logic [1:0]  last_code  = 2'b00;

    // Snapshot taken right after a mid-frame reset cycle.
    logic [25:0] snap;

    // Monitor: log pulses and busy edges, stamped with the clock edge count.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (frame_valid || frame_err) begin
            mon_e = '{stamp: cyc, valid: frame_valid, err: frame_err, code: err_code,
                      data: frame_data, shrt: frame_short};
            ev_q.push_back(mon_e);
        end
        if (frame_valid && frame_err) both_cnt++;
        if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
        if (busy === 1'b0 && busy_prev)  busy_fall = cyc;
        busy_prev = (busy === 1'b1);
    end

    task automatic drive(input logic v);
        @(negedge clk);
        rcvd  = v;
        rst_n = 1'b1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // Drives one full frame (stored bits MSB first), optional one-cycle glitch at
    // mid-sample of bit glitch_pos, optional reset pulse at line cycle rst_at.
    task automatic send_frame(input logic [19:0] bits, input logic pbit, input logic stop_line,
                              input int glitch_pos, input int rst_at, output int s);
        logic line[$];
        logic v;
        s = 0;
        for (int i = 0; i < OSR; i++) line.push_back(1'b1);
        for (int b = 0; b < FRAME_W; b++)
            for (int i = 0; i < OSR; i++) begin
                v = ~bits[FRAME_W-1-b];
                if (b == glitch_pos && i == OSR / 2) v = ~v;
                line.push_back(v);
            end
        for (int i = 0; i < OSR; i++) line.push_back(~pbit);
        for (int i = 0; i < OSR; i++) line.push_back(stop_line);
        for (int k = 0; k < line.size(); k++) begin
            @(negedge clk);
            if (k == 0) s = cyc + 1;
            rcvd  = line[k];
            rst_n = (k == rst_at) ? 1'b0 : 1'b1;
            if (k == rst_at) begin
                @(posedge clk);
                #1;
                snap = {frame_data, frame_valid, frame_err, err_code, frame_short, busy};
            end
        end
        quiet(IDLE_CYC + 6);
    endtask

    // Frame-level reference: decides the outcome from bit values and the
    // protocol rules, then advances the held-output history.
    task automatic model_frame(input logic [19:0] bits, input logic pbit, input logic stop_line,
                               input int glitch_pos, input int s, output ev_t e);
        logic [19:0] eb;
        logic [3:0]  hdr;
        eb = bits;
        if (glitch_pos >= 0 && !MAJ) eb[FRAME_W-1-glitch_pos] = ~eb[FRAME_W-1-glitch_pos];
        hdr = eb[19:16];
        e = '0;
        if (hdr == 4'hC || hdr == 4'h8) begin
            e.stamp = s + SHORT_OFF; e.valid = 1'b1; e.data = {16'h0, hdr}; e.shrt = 1'b1;
            e.code  = last_code;
        end else begin
            e.stamp = s + LONG_OFF;
            if (stop_line) begin
                e.err = 1'b1; e.code = 2'b11; e.data = last_good; e.shrt = last_short;
            end else if ((($countones(eb) + int'(pbit)) % 2) == 0) begin
                e.err = 1'b1; e.code = 2'b10; e.data = last_good; e.shrt = last_short;
            end else begin
                e.valid = 1'b1; e.data = eb; e.shrt = 1'b0; e.code = last_code;
            end
        end
        last_good = e.data; last_short = e.shrt; last_code = e.code;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(negedge clk); rcvd = ~rcvd; end
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", frame_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", frame_err); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b want 00", err_code); end
        checks++; if (frame_data !== 20'h0) begin errors++; $display("FAIL rst_data got %h want 00000", frame_data); end
        checks++; if (frame_short !== 1'b0) begin errors++; $display("FAIL rst_short got %b want 0", frame_short); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        quiet(IDLE_CYC + 6);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rst_quiet_events got %0d want 0", ev_q.size()); end
        ev_q.delete();
    endtask

    // Shared by the directed single-frame scenarios: drive, model, compare inline.
    task automatic test_frame(input string name, input logic [19:0] bits, input logic pbit,
                              input logic stop_line, input int glitch_pos);
        int s; ev_t exp, got;
        send_frame(bits, pbit, stop_line, glitch_pos, -1, s);
        model_frame(bits, pbit, stop_line, glitch_pos, s, exp);
        checks++;
        if (ev_q.size() != 1) begin
            errors++; $display("FAIL %s_count got %0d pulses want 1", name, ev_q.size());
        end else begin
            got = ev_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s_pulse got %p want %p", name, got, exp); end
        end
        checks++;
        if (busy_rise !== s || busy_fall !== exp.stamp) begin
            errors++; $display("FAIL %s_busy got rise %0d fall %0d want %0d %0d", name, busy_rise, busy_fall, s, exp.stamp);
        end
        ev_q.delete();
    endtask

    task automatic test_start_glitch();
        int s, s2; ev_t exp, got;
        @(negedge clk); s = cyc + 1; rcvd = 1'b1;
        quiet(DEC + 30);
        send_frame(20'hA5A5C, 1'b1, 1'b0, -1, -1, s2);   // too early: must be ignored
        exp = '{stamp: s + DEC, valid: 1'b0, err: 1'b1, code: 2'b01, data: last_good, shrt: last_short};
        last_code = 2'b01;
        checks++;
        if (ev_q.size() != 1) begin
            errors++; $display("FAIL glitch_count got %0d pulses want 1", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL glitch_pulse got %p want %p", got, exp); end
        end
        checks++;
        if (busy_rise !== s || busy_fall !== s + DEC) begin
            errors++; $display("FAIL glitch_busy got rise %0d fall %0d want %0d %0d", busy_rise, busy_fall, s, s + DEC);
        end
        ev_q.delete();
        test_frame("glitch_recover", 20'hA5A5C, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        int s;
        send_frame(20'hA5A5C, 1'b1, 1'b0, -1, 10 * OSR + 1, s);
        checks++;
        if (snap !== 26'h0) begin errors++; $display("FAIL midrst_outputs got %h want 0000000", snap); end
        checks++;
        if (ev_q.size() != 0) begin errors++; $display("FAIL midrst_events got %0d want 0", ev_q.size()); end
        ev_q.delete();
        last_good = '0; last_short = 1'b0; last_code = 2'b00;
        test_frame("midrst_after", 20'hA5A5C, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [19:0] bits; logic pbit, stop_line; int s; ev_t exp, got;
        for (int n = 0; n < 16; n++) begin
            bits = 20'($urandom);
            if ($urandom_range(3) == 0) bits[19:16] = ($urandom_range(1) == 0) ? 4'hC : 4'h8;
            pbit = ($urandom_range(2) != 0) ? ~(^bits) : (^bits);
            stop_line = ($urandom_range(4) == 0);
            send_frame(bits, pbit, stop_line, -1, -1, s);
            model_frame(bits, pbit, stop_line, -1, s, exp);
            checks++;
            if (ev_q.size() != 1) begin
                errors++; $display("FAIL rand%0d_count got %0d pulses want 1", n, ev_q.size());
            end else begin
                got = ev_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL rand%0d_pulse got %p want %p", n, got, exp); end
            end
            ev_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_frame("long_good", 20'hA5A5C, 1'b1, 1'b0, -1);
        test_frame("short_hdr", {4'hC, 16'h1234}, 1'b0, 1'b1, -1);
        test_frame("parity_err", 20'hA5A5C, 1'b0, 1'b0, -1);
        test_frame("stop_err", 20'hA5A5C, 1'b1, 1'b1, -1);
        test_start_glitch();
        test_reset_mid();
        test_frame("mid_glitch", 20'hA5A5C, 1'b1, 1'b0, 10);
        test_random();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL valid_err_overlap got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
